// File: rtl/tnn_stream_adapter.sv
// Stream adapter for the TNN core: buffers whole images of wide host words and
// streams them out as narrow pixels, then packs narrow result beats back into wide words.
module tnn_stream_adapter #(
  parameter int WIDE_W      = 512,
  parameter int NARROW_W    = 64,
  parameter int IMG_WORDS   = 16,
  parameter int FIFO_DEPTH  = 32,
  parameter int RES_PER_IMG = 20
) (
  input  logic                aclk,
  input  logic                srst,
  input  logic [WIDE_W-1:0]   in_data,
  input  logic                in_vld,
  output logic                in_rdy,
  output logic [NARROW_W-1:0] pix_data,
  output logic                pix_vld,
  input  logic                pix_rdy,
  output logic                pix_last,
  input  logic [NARROW_W-1:0] res_data,
  input  logic                res_vld,
  output logic                res_rdy,
  output logic [WIDE_W-1:0]   out_data,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic                out_last,
  output logic                img_buffered
);

  localparam int RATIO = WIDE_W / NARROW_W;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int TOTAL = IMG_WORDS * RATIO;
  localparam int PW    = $clog2(TOTAL + 1);
  localparam int BW    = (RES_PER_IMG > 1) ? $clog2(RES_PER_IMG) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] IMG_C     = CW'(IMG_WORDS);
  localparam logic [AW-1:0] PTR_MAX   = AW'(FIFO_DEPTH - 1);
  localparam logic [LW-1:0] LANE_MAX  = LW'(RATIO - 1);
  localparam logic [PW-1:0] PIX_MAX   = PW'(TOTAL - 1);
  localparam logic [PW-1:0] PIX_TOTAL = PW'(TOTAL);
  localparam logic [BW-1:0] BEAT_MAX  = BW'(RES_PER_IMG - 1);

  if (NARROW_W < 1 || WIDE_W < NARROW_W || (WIDE_W % NARROW_W) != 0) begin : g_bad_width
    $error("tnn_stream_adapter: WIDE_W must be a non-zero multiple of NARROW_W");
  end
  if (IMG_WORDS < 1 || RES_PER_IMG < 1) begin : g_bad_img
    $error("tnn_stream_adapter: IMG_WORDS and RES_PER_IMG must be >= 1");
  end
  if (FIFO_DEPTH < IMG_WORDS || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("tnn_stream_adapter: FIFO_DEPTH must be a power of two >= IMG_WORDS");
  end

  typedef logic [RATIO-1:0][NARROW_W-1:0] word_t;
  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  word_t               r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [CW-1:0]       r_count;
  logic                r_img_buf;
  state_t              r_state;
  logic [LW-1:0]       r_lane;
  logic [PW-1:0]       r_pix_idx;
  logic [NARROW_W-1:0] r_pix_data;
  logic                r_pix_vld;
  logic                r_pix_last;

  logic w_push;
  logic w_pop;
  logic w_load;
  logic w_pix_hs;

  assign in_rdy   = !srst && (r_count < DEPTH_C);
  assign w_push   = in_vld && in_rdy;
  assign w_pix_hs = r_pix_vld && pix_rdy;
  // The pixel register reloads whenever it is empty or being drained, which keeps the stream gap-free.
  assign w_load   = (r_state == S_STREAM) && (r_pix_idx != PIX_TOTAL) && (!r_pix_vld || pix_rdy);
  assign w_pop    = w_load && (r_lane == LANE_MAX);

  always_ff @(posedge aclk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_img_buf <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == PTR_MAX) ? '0 : r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == PTR_MAX) ? '0 : r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_img_buf <= (r_count >= IMG_C);
    end
  end

  // Release FSM: one image per STREAM visit, re-armed only from IDLE.
  always_ff @(posedge aclk) begin
    if (srst) begin
      r_state    <= S_IDLE;
      r_lane     <= '0;
      r_pix_idx  <= '0;
      r_pix_data <= '0;
      r_pix_vld  <= 1'b0;
      r_pix_last <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count >= IMG_C) begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_load) begin
            r_pix_data <= r_mem[r_rptr][r_lane];
            r_pix_vld  <= 1'b1;
            r_pix_last <= (r_pix_idx == PIX_MAX);
            r_pix_idx  <= r_pix_idx + 1'b1;
            r_lane     <= (r_lane == LANE_MAX) ? '0 : r_lane + 1'b1;
          end else if (w_pix_hs) begin
            r_pix_vld  <= 1'b0;
            r_pix_last <= 1'b0;
          end
          if (w_pix_hs && r_pix_last) begin
            r_state   <= S_IDLE;
            r_pix_idx <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pix_data     = r_pix_data;
  assign pix_vld      = r_pix_vld;
  assign pix_last     = r_pix_last;
  assign img_buffered = r_img_buf;

  word_t         r_acc;
  word_t         r_hold;
  word_t         r_out;
  logic          r_hold_full;
  logic          r_hold_last;
  logic          r_out_vld;
  logic          r_out_last;
  logic [LW-1:0] r_plane;
  logic [BW-1:0] r_beat;

  logic  w_res_hs;
  logic  w_beat_last;
  logic  w_word_end;
  logic  w_out_free;
  word_t w_word;

  // Stall only when both the output register and the staging word are occupied.
  assign res_rdy     = !srst && !(r_out_vld && !out_rdy && r_hold_full);
  assign w_res_hs    = res_vld && res_rdy;
  assign w_beat_last = (r_beat == BEAT_MAX);
  assign w_word_end  = w_res_hs && ((r_plane == LANE_MAX) || w_beat_last);
  assign w_out_free  = !r_out_vld || out_rdy;

  always_comb begin
    w_word          = r_acc;
    w_word[r_plane] = res_data;
  end

  // Packer: accumulate beats, then bypass straight into the output register or park in the staging word.
  always_ff @(posedge aclk) begin
    if (srst) begin
      r_acc       <= '0;
      r_hold      <= '0;
      r_out       <= '0;
      r_hold_full <= 1'b0;
      r_hold_last <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_last  <= 1'b0;
      r_plane     <= '0;
      r_beat      <= '0;
    end else begin
      if (w_res_hs) begin
        if (w_word_end) begin
          r_acc   <= '0;
          r_plane <= '0;
        end else begin
          r_acc   <= w_word;
          r_plane <= r_plane + 1'b1;
        end
        r_beat <= w_beat_last ? '0 : r_beat + 1'b1;
      end
      if (w_out_free) begin
        if (r_hold_full) begin
          r_out      <= r_hold;
          r_out_last <= r_hold_last;
          r_out_vld  <= 1'b1;
          if (w_word_end) begin
            r_hold      <= w_word;
            r_hold_last <= w_beat_last;
          end else begin
            r_hold_full <= 1'b0;
          end
        end else if (w_word_end) begin
          r_out      <= w_word;
          r_out_last <= w_beat_last;
          r_out_vld  <= 1'b1;
        end else begin
          r_out_vld  <= 1'b0;
          r_out_last <= 1'b0;
        end
      end else if (w_word_end) begin
        r_hold      <= w_word;
        r_hold_last <= w_beat_last;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign out_data = r_out;
  assign out_vld  = r_out_vld;
  assign out_last = r_out_last;

endmodule

// File: tb/tb_tnn_stream_adapter.sv
// Scoreboard bench for tnn_stream_adapter: stimulus pushes expected pixels/words into
// queues, independent monitors pop and compare on every DUT output handshake.
module tb_tnn_stream_adapter;

  logic         aclk = 1'b0;
  logic         srst = 1'b1;
  logic [511:0] in_data = '0;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [63:0]  pix_data;
  logic         pix_vld;
  logic         pix_rdy = 1'b0;
  logic         pix_last;
  logic [63:0]  res_data = '0;
  logic         res_vld = 1'b0;
  logic         res_rdy;
  logic [511:0] out_data;
  logic         out_vld;
  logic         out_rdy = 1'b0;
  logic         out_last;
  logic         img_buffered;

  tnn_stream_adapter dut (
    .aclk(aclk), .srst(srst),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .pix_data(pix_data), .pix_vld(pix_vld), .pix_rdy(pix_rdy), .pix_last(pix_last),
    .res_data(res_data), .res_vld(res_vld), .res_rdy(res_rdy),
    .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .out_last(out_last),
    .img_buffered(img_buffered)
  );

  always #5 aclk = ~aclk;

  typedef struct { logic [63:0] d; logic l; } pix_t;
  typedef struct { logic [511:0] d; logic l; } word_t;

  pix_t  pix_q[$];
  word_t out_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    pix_hs_cnt = 0;
  int    exp_pix_idx = 0;
  int    rdy_mode = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no event expected one", nm);
  endtask

  // pix_rdy driver: 0 = low, 1 = high, 2 = random
  initial begin
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       pix_rdy = 1'b0;
        1:       pix_rdy = 1'b1;
        default: pix_rdy = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Pixel monitor: every valid cycle must show the scoreboard head; pop on handshake.
  initial begin
    forever begin
      @(negedge aclk);
      if (!srst && pix_vld) begin
        if (pix_q.size() == 0) begin
          timeout_fail("pix_unexpected");
        end else begin
          chk("pix_data", 512'(pix_data), 512'(pix_q[0].d));
          chk("pix_last", 512'(pix_last), 512'(pix_q[0].l));
          if (pix_rdy) begin
            void'(pix_q.pop_front());
            pix_hs_cnt++;
          end
        end
      end
    end
  end

  // Output-word monitor.
  initial begin
    forever begin
      @(negedge aclk);
      if (!srst && out_vld && out_rdy) begin
        if (out_q.size() == 0) begin
          timeout_fail("out_unexpected");
        end else begin
          chk("out_data", out_data, out_q[0].d);
          chk("out_last", 512'(out_last), 512'(out_q[0].l));
          void'(out_q.pop_front());
        end
      end
    end
  end

  function automatic logic [511:0] mk_word(input int w);
    logic [511:0] r;
    for (int k = 0; k < 8; k++) r[k*64 +: 64] = {32'(w), 32'(k)};
    return r;
  endfunction

  task automatic push_word(input int w);
    int waited;
    waited = 0;
    in_data = mk_word(w);
    in_vld  = 1'b1;
    @(negedge aclk);
    while (!in_rdy && waited < 300) begin
      @(negedge aclk);
      waited++;
    end
    if (!in_rdy) timeout_fail("push_timeout");
    for (int k = 0; k < 8; k++) begin
      pix_q.push_back('{d: {32'(w), 32'(k)}, l: (exp_pix_idx == 127)});
      exp_pix_idx = (exp_pix_idx + 1) % 128;
    end
    @(posedge aclk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic send_res(input logic [63:0] v);
    int waited;
    waited = 0;
    res_data = v;
    res_vld  = 1'b1;
    @(negedge aclk);
    while (!res_rdy && waited < 100) begin
      @(negedge aclk);
      waited++;
    end
    if (!res_rdy) timeout_fail("res_timeout");
    @(posedge aclk);
    #1;
    res_vld = 1'b0;
  endtask

  // Expected three words for one 20-beat image whose beats are base+1 .. base+20.
  task automatic expect_res_image(input logic [63:0] base);
    logic [511:0] w;
    for (int j = 0; j < 3; j++) begin
      w = '0;
      for (int k = 0; k < 8; k++) begin
        if (j * 8 + k < 20) w[k*64 +: 64] = base + 64'(j * 8 + k + 1);
      end
      out_q.push_back('{d: w, l: (j == 2)});
    end
  endtask

  task automatic wait_pix_drain(input string nm, input int budget);
    int waited;
    waited = 0;
    while (pix_q.size() != 0 && waited < budget) begin
      @(posedge aclk);
      waited++;
    end
    if (pix_q.size() != 0) timeout_fail(nm);
    repeat (4) @(posedge aclk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_cnt;
    int waited;
    int bubbles;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_in_rdy", 512'(in_rdy), 512'(0));
    chk("rst_pix_vld", 512'(pix_vld), 512'(0));
    chk("rst_pix_last", 512'(pix_last), 512'(0));
    chk("rst_pix_data", 512'(pix_data), 512'(0));
    chk("rst_out_vld", 512'(out_vld), 512'(0));
    chk("rst_out_last", 512'(out_last), 512'(0));
    chk("rst_out_data", out_data, 512'(0));
    chk("rst_img_buf", 512'(img_buffered), 512'(0));
    srst = 1'b0;
    #1;
    chk("in_rdy_after_rst", 512'(in_rdy), 512'(1));

    // One image, pix_rdy high
    rdy_mode = 1;
    @(posedge aclk);
    #1;
    base_cnt = pix_hs_cnt;
    for (int w = 0; w < 16; w++) push_word(w);
    chk("img_buf_not_yet", 512'(img_buffered), 512'(0));
    @(posedge aclk);
    #1;
    chk("img_buf_rise", 512'(img_buffered), 512'(1));
    @(posedge aclk);
    #1;
    chk("first_pix_latency", 512'(pix_vld), 512'(1));
    bubbles = 0;
    repeat (128) begin
      @(negedge aclk);
      if (!pix_vld) bubbles++;
    end
    chk("pix_bubbles", 512'(bubbles), 512'(0));
    wait_pix_drain("img1_drain", 200);
    chk("img1_pix_count", 512'(pix_hs_cnt - base_cnt), 512'(128));
    chk("img1_img_buf_low", 512'(img_buffered), 512'(0));

    // Two images with the core stalled: buffer fills to 32
    rdy_mode = 0;
    repeat (2) @(posedge aclk);
    #1;
    base_cnt = pix_hs_cnt;
    for (int w = 0; w < 32; w++) push_word(w);
    chk("in_rdy_full", 512'(in_rdy), 512'(0));
    in_data = mk_word(99);
    in_vld  = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      chk("in_rdy_held_low", 512'(in_rdy), 512'(0));
    end
    @(posedge aclk);
    #1;
    in_vld = 1'b0;
    rdy_mode = 1;
    waited = 0;
    while (!in_rdy && waited < 40) begin
      @(posedge aclk);
      #1;
      waited++;
    end
    chk("in_rdy_reopen", 512'(in_rdy), 512'(1));
    wait_pix_drain("img2_drain", 700);
    chk("img2_pix_count", 512'(pix_hs_cnt - base_cnt), 512'(256));

    // Random backpressure: same sequence as the free-running run
    rdy_mode = 2;
    base_cnt = pix_hs_cnt;
    for (int w = 0; w < 16; w++) push_word(w);
    wait_pix_drain("rand_drain", 2000);
    chk("rand_pix_count", 512'(pix_hs_cnt - base_cnt), 512'(128));
    rdy_mode = 1;

    // Result packing, sink always ready
    out_rdy = 1'b1;
    expect_res_image(64'd0);
    for (int i = 1; i <= 7; i++) send_res(64'(i));
    chk("out_vld_before_word", 512'(out_vld), 512'(0));
    send_res(64'd8);
    chk("out_latency", 512'(out_vld), 512'(1));
    for (int i = 9; i <= 20; i++) send_res(64'(i));
    repeat (4) @(posedge aclk);
    #1;
    chk("res1_drained", 512'(out_q.size()), 512'(0));

    // Result packing with the sink stalled
    @(posedge aclk);
    #1;
    out_rdy = 1'b0;
    expect_res_image(64'h100);
    for (int i = 1; i <= 16; i++) send_res(64'h100 + 64'(i));
    res_data = 64'h100 + 64'd17;
    res_vld  = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      chk("res_rdy_stalled", 512'(res_rdy), 512'(0));
    end
    @(posedge aclk);
    #1;
    out_rdy = 1'b1;
    waited = 0;
    @(negedge aclk);
    while (!res_rdy && waited < 20) begin
      @(negedge aclk);
      waited++;
    end
    if (!res_rdy) timeout_fail("res_resume");
    @(posedge aclk);
    #1;
    res_vld = 1'b0;
    for (int i = 18; i <= 20; i++) send_res(64'h100 + 64'(i));
    repeat (6) @(posedge aclk);
    #1;
    chk("res2_drained", 512'(out_q.size()), 512'(0));

    // Reset mid-image discards buffered pixels and a partial result word
    for (int i = 1; i <= 3; i++) send_res(64'hAA00 + 64'(i));
    base_cnt = pix_hs_cnt;
    for (int w = 0; w < 16; w++) push_word(w);
    waited = 0;
    while (pix_hs_cnt < base_cnt + 40 && waited < 300) begin
      @(posedge aclk);
      #1;
      waited++;
    end
    if (pix_hs_cnt < base_cnt + 40) timeout_fail("reach_pix40");
    srst = 1'b1;
    pix_q.delete();
    exp_pix_idx = 0;
    @(posedge aclk);
    #1;
    chk("mid_rst_pix_vld", 512'(pix_vld), 512'(0));
    chk("mid_rst_pix_last", 512'(pix_last), 512'(0));
    chk("mid_rst_out_vld", 512'(out_vld), 512'(0));
    chk("mid_rst_img_buf", 512'(img_buffered), 512'(0));
    chk("mid_rst_in_rdy", 512'(in_rdy), 512'(0));
    @(posedge aclk);
    #1;
    srst = 1'b0;
    out_q.push_back('{d: {64'hBB08, 64'hBB07, 64'hBB06, 64'hBB05,
                          64'hBB04, 64'hBB03, 64'hBB02, 64'hBB01}, l: 1'b0});
    for (int i = 1; i <= 8; i++) send_res(64'hBB00 + 64'(i));
    base_cnt = pix_hs_cnt;
    for (int w = 0; w < 16; w++) push_word(w);
    wait_pix_drain("post_rst_drain", 300);
    chk("post_rst_pix_count", 512'(pix_hs_cnt - base_cnt), 512'(128));
    chk("post_rst_out_drained", 512'(out_q.size()), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tnn_stream_adapter.md
Name: tnn_stream_adapter

Overview:
- Single-clock, parametrised stream front/back end for the TNN compute core.
- Buffers wide host words until one complete image is resident, then releases it as a backpressured narrow pixel stream with a per-image last marker.
- Packs narrow result beats back into wide words. A partial final word per image is zero-padded and flagged last.
- Sits between the host-facing DMA FIFOs (already in the aclk domain) and the compute core.

Parameters:
- WIDE_W, 512, host word width in bits.
- NARROW_W, 64, pixel/result width. WIDE_W % NARROW_W == 0 is required; RATIO = WIDE_W/NARROW_W.
- IMG_WORDS, 16, wide words per input image, >= 1.
- FIFO_DEPTH, 32, input buffer depth in wide words. Power of two, >= IMG_WORDS.
- RES_PER_IMG, 20, narrow result beats per image, >= 1.
- Any parameter constraint violation is an elaboration-time error.

Ports:
- aclk, in, 1, clock.
- srst, in, 1, synchronous active-high reset.
- in_data, in, WIDE_W, host word.
- in_vld, in, 1, host word valid.
- in_rdy, out, 1, buffer can accept.
- pix_data, out, NARROW_W, pixel to core.
- pix_vld, out, 1, pixel valid.
- pix_rdy, in, 1, core accepts pixel.
- pix_last, out, 1, final pixel of image.
- res_data, in, NARROW_W, result beat from core.
- res_vld, in, 1, result valid.
- res_rdy, out, 1, adapter accepts result.
- out_data, out, WIDE_W, packed result word.
- out_vld, out, 1, packed word valid.
- out_rdy, in, 1, sink accepts.
- out_last, out, 1, final word of image.
- img_buffered, out, 1, registered; high while buffer count >= IMG_WORDS.

Behaviour:
- Handshakes: transfer occurs when vld && rdy on a rising aclk edge. A valid, once asserted, holds with stable data until accepted.
- Input buffer:
  - in_rdy = (count < FIFO_DEPTH). No push is possible when full.
  - Push and pop in the same cycle leave count unchanged.
- Release FSM states: IDLE and STREAM.
  - IDLE -> STREAM when count >= IMG_WORDS.
  - STREAM emits exactly IMG_WORDS*RATIO pixels, then returns to IDLE.
  - A new image is never started mid-stream, even if more than one image is buffered. The next IDLE->STREAM transition occurs the cycle after the last pixel handshake if the condition still holds.
- Downsizing:
  - Lanes are emitted LSB-first: lane k = word[k*NARROW_W +: NARROW_W].
  - The lane index wraps at RATIO-1 and the next word is popped.
  - pix_last = 1 only on pixel IMG_WORDS*RATIO-1 of the image.
  - With pix_rdy held high, the stream is bubble-free across word boundaries.
  - First pix_vld is asserted within 2 cycles of count reaching IMG_WORDS.
  - pix_rdy low freezes pix_data, pix_vld and pix_last.
- Upsizing:
  - Result beats fill lanes LSB-first.
  - A word completes on the RATIO-th beat, or on beat RES_PER_IMG-1 of an image. In the latter case unfilled upper lanes are 0 and out_last = 1.
  - The beat counter wraps per image.
  - Completed word: out_vld is asserted the cycle after the completing handshake (1-cycle latency).
  - res_rdy = !(out_vld && !out_rdy && packer_has_pending_full_word). The packer may collect the next word while the output register is held, and stalls only when both are full.
- img_buffered is registered: it updates the cycle after count changes.
- Reset (srst = 1):
  - Outputs: in_rdy=0 during reset, then 1; all vld, last and img_buffered = 0; data outputs = 0.
  - Internal: buffer empty, FSM IDLE, all lane/beat/word counters 0.
  - Reset mid-image discards all buffered and partially packed data. No partial word is emitted.

Test Plan:
- Defaults, push 16 words where word w lane k = {w[31:0], k[31:0]}, pix_rdy=1 -> img_buffered rises the cycle after the 16th push. 128 contiguous pixels in order w0k0..w15k7, pix_last only on beat 127.
- Push 32 words (two images), in_vld held -> in_rdy low at count 32. Exactly 256 pixels emitted, with pix_last at beats 127 and 255. in_rdy returns high after the first pop.
- pix_rdy random 50% -> pixel sequence identical to the rdy=1 run; pix_data stable on every stalled cycle.
- 20 result beats with values 1..20, out_rdy=1 -> 3 words. Word 2 lanes 0-3 = 17..20, lanes 4-7 = 0, out_last=1 only on word 2.
- out_rdy=0 while feeding results -> res_rdy drops after 16 beats are accepted. Releasing out_rdy drains the words in order, with no loss or duplication.
- srst asserted at pixel 40 of an image -> next cycle all vld=0 and img_buffered=0. A fresh 16-word image afterwards starts at w0k0.
